// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead subtractor.
//
// Contents:
//   CLA_WIDTH / CLA_SLICE - default operand width and bits resolved per stage
//   CLA_NSTAGE            - number of pipeline stages (one lookahead slice each)
//   slice_t               - one SLICE-bit chunk of an operand
//   stage_t               - contents of one pipeline stage register
//   sat_value()           - clamp value used when saturation is compiled in
//
// The stage struct is sized from CLA_WIDTH, so a different width or slice
// size is selected by editing the defaults here rather than by overriding
// the parameters of cla_sub_pipe alone.
package cla_pkg;

  localparam int CLA_WIDTH  = 16;
  localparam int CLA_SLICE  = 4;
  localparam int CLA_NSTAGE = CLA_WIDTH / CLA_SLICE;

  typedef logic [CLA_SLICE-1:0] slice_t;

  // One pipeline stage. The full operands travel with the transaction so the
  // not-yet-resolved upper slices are available to later stages; the bits
  // already consumed are simply left unused downstream.
  typedef struct packed {
    logic                 valid;
    logic [CLA_WIDTH-1:0] d;
    logic                 carry;
    logic [CLA_WIDTH-1:0] a;
    logic [CLA_WIDTH-1:0] b;
    logic                 a_sign;
    logic                 b_sign;
  } stage_t;

  // Most positive value for a non-negative minuend, most negative otherwise.
  function automatic logic [CLA_WIDTH-1:0] sat_value(input logic neg);
    return neg ? {1'b1, {(CLA_WIDTH-1){1'b0}}} : {1'b0, {(CLA_WIDTH-1){1'b1}}};
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder slice.
//
// Ports:
//   a  - first addend slice
//   b  - second addend slice (already inverted by the caller for subtraction)
//   ci - carry into bit 0 of the slice
//   s  - sum slice
//   co - carry out of the top bit of the slice
module cla_slice
  import cla_pkg::*;
(
  input  slice_t a,
  input  slice_t b,
  input  logic   ci,
  output slice_t s,
  output logic   co
);

  slice_t             g;
  slice_t             p;
  logic [CLA_SLICE:0] c;
  logic               acc;
  logic               run_p;

  // Each carry is formed directly as the OR of generate terms gated by the
  // chain of propagates above them, so no carry waits on a lower carry.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    acc   = 1'b0;
    run_p = 1'b0;
    c[0]  = ci;
    for (int i = 0; i < CLA_SLICE; i++) begin
      acc   = g[i];
      run_p = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc   = acc | (run_p & g[j]);
        run_p = run_p & p[j];
      end
      c[i+1] = acc | (run_p & ci);
    end
  end

  assign s  = p ^ c[CLA_SLICE-1:0];
  assign co = c[CLA_SLICE];

endmodule

// File: rtl/cla_sub_pipe.sv
// Pipelined two's-complement subtractor: D = A - B - BI, one lookahead slice
// resolved per stage, valid/ready handshake on both sides.
//
// Ports:
//   CLK       - clock, all state on the rising edge
//   RST       - synchronous active-high reset, clears every stage
//   IN_VALID  - operand set valid
//   IN_READY  - operands are accepted this cycle (low while RST is high)
//   A, B, BI  - minuend, subtrahend, borrow in
//   OUT_VALID - result valid (valid bit of the last stage)
//   OUT_READY - downstream takes the result this cycle
//   D         - difference
//   BO        - borrow out (unsigned A < B + BI)
//   OVF       - signed overflow
//
// Build option:
//   CLA_SUB_SAT_EN - when defined, D clamps to the most positive/negative value
//                    on signed overflow; otherwise D is the wrapped result.
module cla_sub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int SLICE = CLA_SLICE
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             OVF
);

  localparam int NSTAGE = WIDTH / SLICE;

  stage_t             st_q [NSTAGE];
  stage_t             src  [NSTAGE];
  stage_t             nxt  [NSTAGE];
  logic [NSTAGE:0]    ready;
  logic [WIDTH-1:0]   sum_all;
  logic [NSTAGE-1:0]  co_all;
  stage_t             last;
  logic               ovf;

  // What each stage would capture: stage 0 takes the fresh operands with the
  // inverted borrow as its carry-in, every later stage takes its predecessor.
  always_comb begin
    src[0]        = '0;
    src[0].valid  = IN_VALID;
    src[0].carry  = ~BI;
    src[0].a      = A;
    src[0].b      = B;
    src[0].a_sign = A[WIDTH-1];
    src[0].b_sign = B[WIDTH-1];
    for (int k = 1; k < NSTAGE; k++) begin
      src[k] = st_q[k-1];
    end
  end

  // Subtraction is addition of the inverted subtrahend.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_slice
    cla_slice u_slice (
      .a  (src[k].a[k*SLICE +: SLICE]),
      .b  (~src[k].b[k*SLICE +: SLICE]),
      .ci (src[k].carry),
      .s  (sum_all[k*SLICE +: SLICE]),
      .co (co_all[k])
    );
  end

  // Merge this stage's resolved slice and carry into the travelling record.
  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      nxt[k]                      = src[k];
      nxt[k].d[k*SLICE +: SLICE]  = sum_all[k*SLICE +: SLICE];
      nxt[k].carry                = co_all[k];
    end
  end

  // A stage may load when it is empty or its successor is draining it; the
  // chain is resolved from the output end back towards the input.
  always_comb begin
    ready         = '0;
    ready[NSTAGE] = OUT_READY;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      ready[k] = !st_q[k].valid || ready[k+1];
    end
  end

  // Stage registers. A bubble only clears the valid bit so the data fields of
  // an emptied last stage do not flicker; a stalled stage keeps everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NSTAGE; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (ready[k]) begin
          if (nxt[k].valid) begin
            st_q[k] <= nxt[k];
          end else begin
            st_q[k].valid <= 1'b0;
          end
        end
      end
    end
  end

  assign last     = st_q[NSTAGE-1];
  assign IN_READY = ready[0] && !RST;
  assign OUT_VALID = last.valid;

  // Overflow is only possible when the operand signs differ, and shows up as
  // the wrapped sign disagreeing with the minuend's sign.
  assign ovf = (last.a_sign != last.b_sign) && (last.d[WIDTH-1] != last.a_sign);
  assign OVF = ovf;

  // The stored carry resets to 0, so gating with valid keeps BO low out of reset.
  assign BO = last.valid & ~last.carry;

`ifdef CLA_SUB_SAT_EN
  assign D = ovf ? sat_value(last.a_sign) : last.d;
`else
  assign D = last.d;
`endif

endmodule
